// File: rtl/memory_stage_sized.sv
// MEM stage: registers the EX->MEM bundle and owns a byte-addressable data memory.
// Handles B/H/W/D loads and stores with extension, byte enables and fault checks.
module memory_stage_sized #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 512,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                StallM,
  input  logic                FlushM,
  input  logic [XLEN-1:0]     ALUResultE,
  input  logic [XLEN-1:0]     WriteDataE,
  input  logic [REG_BITS-1:0] RdE,
  input  logic [XLEN-1:0]     PCPlus4E,
  input  logic                MemWriteE,
  input  logic                MemReadE,
  input  logic                RegWriteE,
  input  logic [2:0]          Funct3E,
  output logic [XLEN-1:0]     ALUResultM,
  output logic [XLEN-1:0]     PCPlus4M,
  output logic [REG_BITS-1:0] RdM,
  output logic                RegWriteM,
  output logic [XLEN-1:0]     RD_Memory,
  output logic                FaultM
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     wd;
    logic [XLEN-1:0]     pc;
    logic [REG_BITS-1:0] rd;
    logic                mw;
    logic                mr;
    logic                rw;
    logic [2:0]          f3;
  } ex_mem_t;

  ex_mem_t r_m;
  ex_mem_t w_e;

  logic [XLEN-1:0] r_mem [DEPTH];

  logic [OB-1:0]   w_off;
  logic [AW-1:0]   w_idx;
  logic [OB+2:0]   w_sh_amt;
  logic            w_mis;
  logic            w_ill;
  logic            w_fault;
  logic            w_we;
  logic [NB-1:0]   w_sz;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdat;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_mask;
  logic            w_sbit;
  logic [XLEN-1:0] w_ext;

  always_comb begin
    w_e    = '0;
    w_e.alu = ALUResultE;
    w_e.wd  = WriteDataE;
    w_e.pc  = PCPlus4E;
    w_e.rd  = RdE;
    w_e.mw  = MemWriteE;
    w_e.mr  = MemReadE;
    w_e.rw  = RegWriteE;
    w_e.f3  = Funct3E;
  end

  // Flush wins over stall so a bubble always lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m <= '0;
    end else if (FlushM) begin
      r_m <= '0;
    end else if (!StallM) begin
      r_m <= w_e;
    end
  end

  assign w_off    = r_m.alu[OB-1:0];
  assign w_idx    = r_m.alu[OB +: AW];
  assign w_sh_amt = {w_off, 3'b000};

  always_comb begin
    w_mis = 1'b0;
    unique case (r_m.f3[1:0])
      2'b01:   w_mis = r_m.alu[0];
      2'b10:   w_mis = |r_m.alu[1:0];
      2'b11:   w_mis = |r_m.alu[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_ill = (r_m.f3 == 3'b111) ||
                 ((XLEN == 32) &&
                  ((r_m.f3 == 3'b011) || (r_m.f3 == 3'b110)));

  assign w_fault = (r_m.mr | r_m.mw) & (w_mis | w_ill);

  always_comb begin
    w_sz = '1;
    unique case (r_m.f3[1:0])
      2'b00:   w_sz = NB'(8'h01);
      2'b01:   w_sz = NB'(8'h03);
      2'b10:   w_sz = NB'(8'h0F);
      default: w_sz = '1;
    endcase
  end

  assign w_be   = w_sz << w_off;
  assign w_wdat = r_m.wd << w_sh_amt;
  assign w_we   = r_m.mw & ~w_fault;

  // Reset low on the edge suppresses the store.
  always_ff @(posedge clock) begin
    if (reset && w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> w_sh_amt;

  always_comb begin
    w_mask = '1;
    w_sbit = 1'b0;
    unique case (r_m.f3[1:0])
      2'b00: begin
        w_mask = XLEN'(64'hFF);
        w_sbit = w_sh[7];
      end
      2'b01: begin
        w_mask = XLEN'(64'hFFFF);
        w_sbit = w_sh[15];
      end
      2'b10: begin
        w_mask = XLEN'(64'hFFFF_FFFF);
        w_sbit = w_sh[31];
      end
      default: begin
        w_mask = '1;
        w_sbit = 1'b0;
      end
    endcase
  end

  assign w_ext = (w_sh & w_mask) |
                 ((~r_m.f3[2] & w_sbit) ? ~w_mask : '0);

  assign RD_Memory  = (r_m.mr & ~w_fault) ? w_ext : '0;
  assign FaultM     = w_fault;
  assign ALUResultM = r_m.alu;
  assign PCPlus4M   = r_m.pc;
  assign RdM        = r_m.rd;
  assign RegWriteM  = r_m.rw;

endmodule

// File: tb/tb_memory_stage_sized.sv
// Bench for memory_stage_sized: directed ops, queued expectations,
// a monitor compares M outputs of a 64-bit and a 32-bit build.
module tb_memory_stage_sized;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        StallM = 1'b0;
  logic        FlushM = 1'b0;
  logic [63:0] ALUResultE = '0;
  logic [63:0] WriteDataE = '0;
  logic [63:0] PCPlus4E = '0;
  logic [4:0]  RdE = '0;
  logic        MemWriteE = 1'b0;
  logic        MemReadE = 1'b0;
  logic        RegWriteE = 1'b0;
  logic [2:0]  Funct3E = '0;

  logic [63:0] ALUResultM, PCPlus4M, RD_Memory;
  logic [4:0]  RdM;
  logic        RegWriteM, FaultM;

  logic [31:0] ALU32, PC32, RD32;
  logic [4:0]  Rd32;
  logic        RW32, F32;

  memory_stage_sized #(.XLEN(64), .DEPTH(512), .REG_BITS(5)) u64 (
    .clock(clock), .reset(reset),
    .StallM(StallM), .FlushM(FlushM),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RdE(RdE), .PCPlus4E(PCPlus4E),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .RegWriteE(RegWriteE), .Funct3E(Funct3E),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM),
    .RD_Memory(RD_Memory), .FaultM(FaultM)
  );

  memory_stage_sized #(.XLEN(32), .DEPTH(512), .REG_BITS(5)) u32 (
    .clock(clock), .reset(reset),
    .StallM(StallM), .FlushM(FlushM),
    .ALUResultE(ALUResultE[31:0]), .WriteDataE(WriteDataE[31:0]),
    .RdE(RdE), .PCPlus4E(PCPlus4E[31:0]),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .RegWriteE(RegWriteE), .Funct3E(Funct3E),
    .ALUResultM(ALU32), .PCPlus4M(PC32),
    .RdM(Rd32), .RegWriteM(RW32),
    .RD_Memory(RD32), .FaultM(F32)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [63:0] alu;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] rdv;
    logic        f;
    bit          c32;
    logic [31:0] rd32;
    logic        f32;
  } exp_t;

  exp_t q[$];
  exp_t pv;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".alu"}, ALUResultM, e.alu);
      chk({e.nm, ".pc"}, PCPlus4M, e.pc);
      chk({e.nm, ".rd"}, {59'b0, RdM}, {59'b0, e.rd});
      chk({e.nm, ".rw"}, {63'b0, RegWriteM}, {63'b0, e.rw});
      chk({e.nm, ".data"}, RD_Memory, e.rdv);
      chk({e.nm, ".fault"}, {63'b0, FaultM}, {63'b0, e.f});
      if (e.c32) begin
        chk({e.nm, ".data32"}, {32'b0, RD32}, {32'b0, e.rd32});
        chk({e.nm, ".fault32"}, {63'b0, F32}, {63'b0, e.f32});
      end
    end
  end

  task automatic issue(
    input string nm, input bit mw, input bit mr,
    input bit [2:0] f3, input bit [63:0] a, input bit [63:0] wd,
    input bit [63:0] erd, input bit ef,
    input bit st = 0, input bit fl = 0,
    input bit c32 = 0, input bit [31:0] erd32 = 0,
    input bit ef32 = 0);
    exp_t e;
    @(negedge clock);
    n++;
    MemWriteE  = mw;
    MemReadE   = mr;
    RegWriteE  = mr;
    Funct3E    = f3;
    ALUResultE = a;
    WriteDataE = wd;
    RdE        = 5'(n);
    PCPlus4E   = 64'h100 + 64'(4 * n);
    StallM     = st;
    FlushM     = fl;
    if (fl) begin
      pv.alu = '0;
      pv.pc  = '0;
      pv.rd  = '0;
      pv.rw  = 1'b0;
    end else if (!st) begin
      pv.alu = a;
      pv.pc  = PCPlus4E;
      pv.rd  = 5'(n);
      pv.rw  = mr;
    end
    e      = pv;
    e.nm   = nm;
    e.rdv  = erd;
    e.f    = ef;
    e.c32  = c32;
    e.rd32 = erd32;
    e.f32  = ef32;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    MemWriteE = 1'b0;
    MemReadE  = 1'b0;
    RegWriteE = 1'b0;
    FlushM    = 1'b0;
    StallM    = 1'b1;
  endtask

  initial begin
    pv = '{nm: "", alu: '0, pc: '0, rd: '0, rw: 1'b0,
           rdv: '0, f: 1'b0, c32: 1'b0, rd32: '0, f32: 1'b0};
    #3;
    chk("rst.alu", ALUResultM, 64'h0);
    chk("rst.pc", PCPlus4M, 64'h0);
    chk("rst.data", RD_Memory, 64'h0);
    chk("rst.fault", {63'b0, FaultM}, 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    issue("sd8", 1, 0, 3'b011, 64'h8, 64'hDEADBEEFDEADBEEF, 0, 0);
    issue("ld8", 0, 1, 3'b011, 64'h8, 0, 64'hDEADBEEFDEADBEEF, 0);
    issue("sb9", 1, 0, 3'b000, 64'h9, 64'h80, 0, 0);
    issue("lb9", 0, 1, 3'b000, 64'h9, 0, 64'hFFFFFFFFFFFFFF80, 0);
    issue("lbu9", 0, 1, 3'b100, 64'h9, 0, 64'h80, 0);
    issue("ld8b", 0, 1, 3'b011, 64'h8, 0, 64'hDEADBEEFDEAD80EF, 0);
    issue("sd0", 1, 0, 3'b011, 64'h0, 64'h1122334455667788, 0, 0);
    issue("sh3", 1, 0, 3'b001, 64'h3, 64'h1234, 0, 1,
          0, 0, 1, 0, 1);
    issue("ld0", 0, 1, 3'b011, 64'h0, 0, 64'h1122334455667788, 0);
    issue("lw2", 0, 1, 3'b010, 64'h2, 0, 0, 1);
    issue("f111", 0, 1, 3'b111, 64'h0, 0, 0, 1,
          0, 0, 1, 0, 1);
    issue("lh2", 0, 1, 3'b001, 64'h2, 0, 64'h5566, 0);
    issue("lw4", 0, 1, 3'b010, 64'h4, 0, 64'h11223344, 0);
    issue("lw0", 0, 1, 3'b010, 64'h0, 0, 64'h55667788, 0);
    issue("sdwrap", 1, 0, 3'b011, 64'h1008, 64'h55, 0, 0);
    issue("ldwrap", 0, 1, 3'b011, 64'h8, 0, 64'h55, 0);
    issue("shA", 1, 0, 3'b001, 64'hA, 64'hABCD, 0, 0);
    issue("ld8c", 0, 1, 3'b011, 64'h8, 0, 64'hABCD0055, 0);
    issue("lhA", 0, 1, 3'b001, 64'hA, 0, 64'hFFFFFFFFFFFFABCD, 0);
    issue("sd10", 1, 0, 3'b011, 64'h10, 64'h0123, 0, 0);
    issue("sdfl", 1, 0, 3'b011, 64'h10, 64'hFFFF, 0, 0, 0, 1);
    issue("ld10", 0, 1, 3'b011, 64'h10, 0, 64'h0123, 0);
    issue("ldst0", 0, 1, 3'b011, 64'h8, 0, 64'hABCD0055, 0);
    issue("stall1", 0, 1, 3'b011, 64'h0, 0, 64'hABCD0055, 0, 1);
    issue("stall2", 0, 1, 3'b000, 64'h0, 0, 64'hABCD0055, 0, 1);
    issue("stall3", 0, 1, 3'b010, 64'h0, 0, 64'hABCD0055, 0, 1);
    issue("flst", 0, 1, 3'b011, 64'h0, 0, 0, 0, 1, 1);
    issue("sw40", 1, 0, 3'b010, 64'h40, 64'h80000000, 0, 0);
    issue("lw40", 0, 1, 3'b010, 64'h40, 0, 64'hFFFFFFFF80000000, 0,
          0, 0, 1, 32'h80000000, 0);
    issue("ld32", 0, 1, 3'b011, 64'h8, 0, 64'hABCD0055, 0,
          0, 0, 1, 0, 1);
    idle();

    @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    chk("arst.alu", ALUResultM, 64'h0);
    chk("arst.pc", PCPlus4M, 64'h0);
    chk("arst.rd", {59'b0, RdM}, 64'h0);
    chk("arst.rw", {63'b0, RegWriteM}, 64'h0);
    chk("arst.data", RD_Memory, 64'h0);
    chk("arst.fault", {63'b0, FaultM}, 64'h0);
    pv.alu = '0;
    pv.pc  = '0;
    pv.rd  = '0;
    pv.rw  = 1'b0;
    @(negedge clock);
    StallM = 1'b0;
    reset  = 1'b1;

    issue("post0", 0, 1, 3'b011, 64'h0, 0, 64'h1122334455667788, 0);
    issue("post10", 0, 1, 3'b011, 64'h10, 0, 64'h0123, 0);
    idle();

    repeat (3) @(posedge clock);
    #3;
    chk("queue_drain", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
